// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator: RV32I immediate formats plus shift amount, sign-extended to XLEN,
// behind a valid/ready handshake with a main register and one skid slot so in_ready is flop-driven.
module imm_gen_stage #(
  parameter int XLEN       = 32,
  parameter int TAG_W      = 32,
  parameter bit SHAMT_MODE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [31:0]      imm32_s;
  logic [XLEN-1:0]  dec_imm_s;
  logic [2:0]       dec_fmt_s;
  logic             dec_ill_s;
  logic             accept_s;
  logic             fire_s;

  logic             main_valid_r;
  logic [XLEN-1:0]  main_imm_r;
  logic [2:0]       main_fmt_r;
  logic             main_ill_r;
  logic [TAG_W-1:0] main_tag_r;
  logic             skid_valid_r;
  logic [XLEN-1:0]  skid_imm_r;
  logic [2:0]       skid_fmt_r;
  logic             skid_ill_r;
  logic [TAG_W-1:0] skid_tag_r;

  // Decode the incoming word: build a 32-bit sign-correct immediate, then widen to XLEN
  always_comb begin
    imm32_s   = 32'h0000_0000;
    dec_fmt_s = FMT_NONE;
    dec_ill_s = 1'b0;
    dec_imm_s = {XLEN{1'b0}};
    case (in_instr[6:0])
      OP_IMM: begin
        if (SHAMT_MODE && (in_instr[14:12] == 3'b001 || in_instr[14:12] == 3'b101)) begin
          dec_fmt_s = FMT_SHAMT;
        end else begin
          imm32_s   = {{20{in_instr[31]}}, in_instr[31:20]};
          dec_fmt_s = FMT_I;
        end
      end
      OP_LOAD, OP_JALR, OP_SYSTEM: begin
        imm32_s   = {{20{in_instr[31]}}, in_instr[31:20]};
        dec_fmt_s = FMT_I;
      end
      OP_STORE: begin
        imm32_s   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        dec_fmt_s = FMT_S;
      end
      OP_BRANCH: begin
        imm32_s   = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                     in_instr[11:8], 1'b0};
        dec_fmt_s = FMT_B;
      end
      OP_LUI, OP_AUIPC: begin
        imm32_s   = {in_instr[31:12], 12'h000};
        dec_fmt_s = FMT_U;
      end
      OP_JAL: begin
        imm32_s   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};
        dec_fmt_s = FMT_J;
      end
      default: begin
        dec_ill_s = 1'b1;
      end
    endcase
    // Shift amounts are zero-extended; RV64 uses the 6-bit field
    if (dec_fmt_s == FMT_SHAMT) begin
      dec_imm_s[5:0] = (XLEN == 64) ? in_instr[25:20] : {1'b0, in_instr[24:20]};
    end else begin
      dec_imm_s       = {XLEN{imm32_s[31]}};
      dec_imm_s[31:0] = imm32_s;
    end
  end

  assign in_ready  = ~skid_valid_r;
  assign accept_s  = in_valid & ~skid_valid_r;
  assign fire_s    = main_valid_r & out_ready;

  // Main/skid occupancy and data: skid refills main first, otherwise new beats go to main when it frees up
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid_r <= 1'b0;
      main_imm_r   <= {XLEN{1'b0}};
      main_fmt_r   <= FMT_NONE;
      main_ill_r   <= 1'b0;
      main_tag_r   <= {TAG_W{1'b0}};
      skid_valid_r <= 1'b0;
      skid_imm_r   <= {XLEN{1'b0}};
      skid_fmt_r   <= FMT_NONE;
      skid_ill_r   <= 1'b0;
      skid_tag_r   <= {TAG_W{1'b0}};
    end else if (flush) begin
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (fire_s && skid_valid_r) begin
      main_imm_r   <= skid_imm_r;
      main_fmt_r   <= skid_fmt_r;
      main_ill_r   <= skid_ill_r;
      main_tag_r   <= skid_tag_r;
      skid_valid_r <= 1'b0;
    end else if (accept_s && (!main_valid_r || fire_s)) begin
      main_valid_r <= 1'b1;
      main_imm_r   <= dec_imm_s;
      main_fmt_r   <= dec_fmt_s;
      main_ill_r   <= dec_ill_s;
      main_tag_r   <= in_tag;
    end else if (accept_s) begin
      skid_valid_r <= 1'b1;
      skid_imm_r   <= dec_imm_s;
      skid_fmt_r   <= dec_fmt_s;
      skid_ill_r   <= dec_ill_s;
      skid_tag_r   <= in_tag;
    end else if (fire_s) begin
      main_valid_r <= 1'b0;
    end else begin
      main_valid_r <= main_valid_r;
    end
  end

  assign out_valid   = main_valid_r;
  assign out_imm     = main_imm_r;
  assign out_fmt     = main_fmt_r;
  assign out_illegal = main_ill_r;
  assign out_tag     = main_tag_r;

endmodule
